// File: rtl/vram_pixel_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_pixel_writer_if
// Description : Pixel stream plus video-RAM user-port command/write bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_pixel_writer_if;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;

  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full;

  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full;
  logic [6:0]  wr_count;

  // master: the pixel writer (sinks pixels, drives the memory port)
  modport master (
    input  pix_valid, pix_data, cmd_full, wr_full, wr_count,
    output pix_ready, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
           wr_en, wr_data, wr_mask
  );

  modport slave (
    output pix_valid, pix_data, cmd_full, wr_full, wr_count,
    input  pix_ready, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
           wr_en, wr_data, wr_mask
  );
endinterface
`default_nettype wire

// File: rtl/vram_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : vram_pixel_writer
// Description : Packs 8-bit pixels into 32-bit words and writes one frame
//               linearly from BASE_ADDR in bursts through a video-RAM port.
//               Optional VRAM_WRITER_KEYMASK_EN: pixels equal to KEY are masked.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_pixel_writer #(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned BURST_WORDS = 32,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter logic [7:0]  KEY         = 8'h00
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic calib_done,
  input  wire logic start,
  output logic      busy,
  output logic      frame_done,
  vram_pixel_writer_if.master bus
);

  localparam int unsigned           c_word_w      = $clog2(FRAME_WORDS + 1);
  localparam logic [c_word_w-1:0]   c_frame_words = c_word_w'(FRAME_WORDS);
  localparam logic [6:0]            c_burst_words = 7'(BURST_WORDS);
  localparam logic [29:0]           c_base        = 30'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_CMD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_lane;
  logic [c_word_w-1:0] r_word_cnt;
  logic [c_word_w-1:0] r_burst_base;
  logic [6:0]          r_burst_cnt;
  logic [23:0]         r_pix;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_cmd_en;
  logic [5:0]          r_cmd_bl;
  logic [29:0]         r_cmd_addr;
  logic                r_wr_en;
  logic [31:0]         r_wr_data;

  logic                w_lane3_ok;
  logic                w_pix_ready;
  logic                w_accept;
  logic [c_word_w-1:0] w_word_next;
  logic [6:0]          w_burst_next;
  logic                w_burst_end;
  logic [29:0]         w_burst_off;

  // One FIFO slot is held back so the registered push can never overflow.
  assign w_lane3_ok   = !bus.wr_full && (bus.wr_count < 7'd63);
  assign w_pix_ready  = (r_state == S_FILL) && ((r_lane != 2'd3) || w_lane3_ok);
  assign w_accept     = w_pix_ready && bus.pix_valid;
  assign w_word_next  = r_word_cnt + 1'b1;
  assign w_burst_next = r_burst_cnt + 7'd1;
  assign w_burst_end  = (w_burst_next == c_burst_words) || (w_word_next == c_frame_words);
  assign w_burst_off  = 30'(r_burst_base) << 2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_lane       <= 2'd0;
      r_word_cnt   <= '0;
      r_burst_base <= '0;
      r_burst_cnt  <= 7'd0;
      r_pix        <= 24'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cmd_en     <= 1'b0;
      r_cmd_bl     <= 6'd0;
      r_cmd_addr   <= 30'd0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= 32'd0;
    end else begin
      r_wr_en      <= 1'b0;
      r_cmd_en     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && calib_done) begin
            r_state      <= S_FILL;
            r_busy       <= 1'b1;
            r_lane       <= 2'd0;
            r_word_cnt   <= '0;
            r_burst_base <= '0;
            r_burst_cnt  <= 7'd0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_pix[7:0]   <= bus.pix_data;
              2'd1: r_pix[15:8]  <= bus.pix_data;
              2'd2: r_pix[23:16] <= bus.pix_data;
              default: begin
                r_wr_data   <= {bus.pix_data, r_pix};
                r_wr_en     <= 1'b1;
                r_word_cnt  <= w_word_next;
                r_burst_cnt <= w_burst_next;
                if (w_burst_end) begin
                  r_state <= S_CMD;
                end
              end
            endcase
          end
        end
        S_CMD: begin
          if (!bus.cmd_full) begin
            r_cmd_en     <= 1'b1;
            r_cmd_bl     <= 6'(r_burst_cnt - 7'd1);
            r_cmd_addr   <= c_base + w_burst_off;
            r_burst_base <= r_word_cnt;
            r_burst_cnt  <= 7'd0;
            r_state      <= (r_word_cnt == c_frame_words) ? S_DONE : S_FILL;
          end
        end
        default: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef VRAM_WRITER_KEYMASK_EN
  logic [2:0] r_key_acc;
  logic [3:0] r_wr_mask;

  // Mask bits travel with their pixels and are published with the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_acc <= 3'd0;
      r_wr_mask <= 4'd0;
    end else if ((r_state == S_FILL) && w_accept) begin
      case (r_lane)
        2'd0:    r_key_acc[0] <= (bus.pix_data == KEY);
        2'd1:    r_key_acc[1] <= (bus.pix_data == KEY);
        2'd2:    r_key_acc[2] <= (bus.pix_data == KEY);
        default: r_wr_mask    <= {(bus.pix_data == KEY), r_key_acc};
      endcase
    end
  end

  assign bus.wr_mask = r_wr_mask;
`else
  logic w_unused_key;
  assign w_unused_key = ^KEY;
  assign bus.wr_mask  = 4'b0000;
`endif

  assign bus.pix_ready     = w_pix_ready;
  assign bus.cmd_en        = r_cmd_en;
  assign bus.cmd_instr     = 3'b000;
  assign bus.cmd_bl        = r_cmd_bl;
  assign bus.cmd_byte_addr = r_cmd_addr;
  assign bus.wr_en         = r_wr_en;
  assign bus.wr_data       = r_wr_data;
  assign busy              = r_busy;
  assign frame_done        = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_vram_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_pixel_writer
// Description : Directed bench for vram_pixel_writer (4-word bursts, 10-word
//               frame at 0x100); VRAM_WRITER_KEYMASK_EN adds a key-mask step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_pixel_writer;

  localparam int unsigned BW = 4;
  localparam int unsigned FW = 10;
  localparam int unsigned BA = 32'h100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic calib_done = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;

  vram_pixel_writer_if bus ();

  vram_pixel_writer #(
    .BASE_ADDR  (BA),
    .BURST_WORDS(BW),
    .FRAME_WORDS(FW),
    .KEY        (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .calib_done(calib_done),
    .start     (start),
    .busy      (busy),
    .frame_done(frame_done),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_frame_done = 0;

  logic [31:0] q_wr_data[$];
  logic [3:0]  q_wr_mask[$];
  logic [29:0] q_cmd_addr[$];
  logic [5:0]  q_cmd_bl[$];

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      q_wr_data.push_back(bus.wr_data);
      q_wr_mask.push_back(bus.wr_mask);
    end
    if (bus.cmd_en === 1'b1) begin
      q_cmd_addr.push_back(bus.cmd_byte_addr);
      q_cmd_bl.push_back(bus.cmd_bl);
    end
    if (frame_done === 1'b1) n_frame_done++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_pix_ready"}, bus.pix_ready, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_cmd_en"}, bus.cmd_en, 0);
    check({pfx, "_wr_en"}, bus.wr_en, 0);
    check({pfx, "_cmd_instr"}, bus.cmd_instr, 0);
    check({pfx, "_cmd_bl"}, bus.cmd_bl, 0);
    check({pfx, "_cmd_addr"}, bus.cmd_byte_addr, 0);
    check({pfx, "_wr_data"}, bus.wr_data, 0);
    check({pfx, "_wr_mask"}, bus.wr_mask, 0);
  endtask

  // Offer one pixel and return just after the edge that accepts it.
  task automatic send_pixel(input logic [7:0] v);
    int n;
    n = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = v;
    @(negedge clk);
    while (bus.pix_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pix_accept", bus.pix_ready, 1);
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [29:0] exp_addr[3];
    logic [5:0]  exp_bl[3];
    logic [31:0] exp_word;
    logic [3:0]  exp_mask;
    int          n;

    exp_addr = '{30'h100, 30'h110, 30'h120};
    exp_bl   = '{6'd3, 6'd3, 6'd1};

    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    bus.cmd_full  = 1'b0;
    bus.wr_full   = 1'b0;
    bus.wr_count  = 7'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Calibration gating
    calib_done = 1'b0;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("gate_busy", busy, 0);
    check("gate_pix_ready", bus.pix_ready, 0);
    calib_done = 1'b1;
    pulse_start();
    check("start_busy", busy, 1);
    check("start_pix_ready", bus.pix_ready, 1);

    // Write backpressure on lane 3
    send_pixel(8'hA0);
    send_pixel(8'hA1);
    send_pixel(8'hA2);
    bus.wr_full   = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'hA3;
    repeat (4) begin
      @(negedge clk);
      check("bp_pix_ready", bus.pix_ready, 0);
      @(posedge clk);
      #1;
      check("bp_no_push", bus.wr_en, 0);
    end
    bus.wr_full  = 1'b0;
    bus.wr_count = 7'd63;
    @(negedge clk);
    check("wrcount63_pix_ready", bus.pix_ready, 0);
    bus.wr_count = 7'd62;
    #1;
    check("wrcount62_pix_ready", bus.pix_ready, 1);
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.wr_count  = 7'd0;
    check("bp_push", bus.wr_en, 1);
    check("bp_data", bus.wr_data, 32'hA3A2A1A0);

    // Command stall: words 1..3 complete burst 0
    for (int i = 0; i < 11; i++) send_pixel(8'hB0 + 8'(i));
    bus.cmd_full = 1'b1;
    send_pixel(8'hBB);
    check("stall_last_push", bus.wr_en, 1);
    check("stall_last_data", bus.wr_data, 32'hBBBAB9B8);
    repeat (5) begin
      @(negedge clk);
      check("stall_pix_ready", bus.pix_ready, 0);
      check("stall_cmd_en", bus.cmd_en, 0);
      @(posedge clk);
      #1;
    end
    bus.cmd_full = 1'b0;
    @(posedge clk);
    #1;
    check("stall_cmd_fire", bus.cmd_en, 1);
    check("stall_cmd_addr", bus.cmd_byte_addr, 30'h100);
    check("stall_cmd_bl", bus.cmd_bl, 6'd3);
    check("stall_cmd_instr", bus.cmd_instr, 3'b000);
    @(posedge clk);
    #1;
    check("stall_cmd_once", bus.cmd_en, 0);
    check("stall_cmd_count", q_cmd_addr.size(), 1);

    // Reset mid-frame: one more word plus two stray pixels
    for (int i = 0; i < 6; i++) send_pixel(8'hC0 + 8'(i));
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    q_wr_data.delete();
    q_wr_mask.delete();
    q_cmd_addr.delete();
    q_cmd_bl.delete();
    n_frame_done = 0;

    // Full frame, pixels 0..39 streamed back to back
    pulse_start();
    for (int p = 0; p < 40; p++) begin
      send_pixel(8'(p));
      if (p % 4 == 3) check("frame_wr_latency", bus.wr_en, 1);
    end
    n = 0;
    while (frame_done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", frame_done, 1);
    @(posedge clk);
    #1;
    check("frame_busy_low", busy, 0);
    check("frame_done_pulse", frame_done, 0);
    @(negedge clk);
    check("frame_push_count", q_wr_data.size(), 10);
    check("frame_cmd_count", q_cmd_addr.size(), 3);
    check("frame_done_count", n_frame_done, 1);
    for (int k = 0; k < 10; k++) begin
      if (k < q_wr_data.size()) begin
        exp_word = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
`ifdef VRAM_WRITER_KEYMASK_EN
        exp_mask = (k == 0) ? 4'b0001 : 4'b0000;
`else
        exp_mask = 4'b0000;
`endif
        check($sformatf("frame_word%0d", k), q_wr_data[k], exp_word);
        check($sformatf("frame_mask%0d", k), q_wr_mask[k], exp_mask);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (k < q_cmd_addr.size()) begin
        check($sformatf("frame_cmd_addr%0d", k), q_cmd_addr[k], exp_addr[k]);
        check($sformatf("frame_cmd_bl%0d", k), q_cmd_bl[k], exp_bl[k]);
      end
    end

`ifdef VRAM_WRITER_KEYMASK_EN
    // Key mask: KEY = 0
    pulse_start();
    send_pixel(8'h00);
    send_pixel(8'h11);
    send_pixel(8'h00);
    send_pixel(8'h33);
    check("key_push", bus.wr_en, 1);
    check("key_data", bus.wr_data, 32'h33001100);
    check("key_mask", bus.wr_mask, 4'b0101);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_pixel_writer.md
# vram_pixel_writer

Bus-master for one write-only user port of the DDR2 video-RAM controller. Takes a stream of 8-bit Mandelbrot pixel values from the compute engine and packs four pixels per 32-bit word. Pushes the words into the port write FIFO and issues one write command per completed burst, so one frame lands linearly from `BASE_ADDR`. Sits between the iteration engine and video-RAM port 1; the display scan-out owns port 0.

## Interface

Parameters:
- `BASE_ADDR`, 0: byte address of pixel 0. Must be 4-byte aligned.
- `BURST_WORDS`, 32: words per write command, 1..64; `cmd_bl` = `BURST_WORDS-1`.
- `FRAME_WORDS`, 76800: words per frame (640x480 / 4). Pixel count per frame is exactly 4*`FRAME_WORDS`.
- `KEY`, 8'h00: transparent pixel value, used only with `VRAM_WRITER_KEYMASK_EN`.

Ports:
- `clk`  in  1  port clock; same net as the port's cmd/wr clock.
- `reset`  in  1  **one clock; reset is asynchronous and active-low**.
- `calib_done`  in  1  memory calibration complete.
- `start`  in  1  one-cycle pulse that begins a frame at pixel 0.
- `pix_valid`  in  1  pixel offered.
- `pix_data`  in  8  pixel value.
- `pix_ready`  out  1  pixel accepted when `pix_valid && pix_ready`.
- `busy`  out  1  high from accepted `start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse after the last command of a frame.
- `cmd_en`  out  1  write command strobe.
- `cmd_instr`  out  3  always 3'b000 (write).
- `cmd_bl`  out  6  burst length minus one.
- `cmd_byte_addr`  out  30  burst start byte address.
- `cmd_full`  in  1  command FIFO full.
- `wr_en`  out  1  write-FIFO push.
- `wr_data`  out  32  packed word.
- `wr_mask`  out  4  byte-lane mask; 1 = lane not written.
- `wr_full`  in  1  write FIFO full.
- `wr_count`  in  7  write FIFO occupancy.

## Operation

- States: IDLE, FILL, CMD, DONE.
- **IDLE:** `start && calib_done` -> FILL; clears the word, burst and lane counters. `start` is ignored while `calib_done` is low and in every other state.
- **FILL:** `pix_ready` = 1 for lanes 0-2.
  - For lane 3, `pix_ready` = `!wr_full && wr_count < 63`. This leaves one slot of margin for the registered push.
  - Packing is little-endian: the first pixel of a word goes to `wr_data[7:0]` and the fourth to `[31:24]`.
  - When lane 3 is accepted, the next cycle drives `wr_en`=1 for one cycle with the packed word, and the word counter increments.
  - When `burst_cnt` reaches `BURST_WORDS`, or the frame's total word count reaches `FRAME_WORDS`, the state goes to CMD on the same cycle as that `wr_en`.
- **CMD:** `pix_ready`=0.
  - Assert `cmd_en` for exactly one cycle, on the first cycle with `!cmd_full`. The earliest such cycle is the one after the final `wr_en`, so the data always precedes its command.
  - `cmd_byte_addr` = `BASE_ADDR + 4*words_before_burst`.
  - `cmd_bl` = `words_in_burst - 1`. The last burst may be short (`FRAME_WORDS mod BURST_WORDS`).
  - Then go to FILL, or to DONE if the frame is complete.
- **DONE:** `frame_done`=1 for one cycle, `busy` drops, and the state returns to IDLE.
- Address arithmetic is 30-bit. The word counter is `ceil(log2(FRAME_WORDS+1))` bits and wraps only by restarting the frame.
- Reset mid-frame: return to IDLE immediately and discard any partially packed pixels. No command is issued for words already pushed, because the MCB FIFOs are reset through the controller's own reset.

## Timing

- Reset values: `pix_ready`, `busy`, `frame_done`, `cmd_en`, `wr_en` = 0; `cmd_instr`=3'b000; `cmd_bl`=0; `cmd_byte_addr`=0; `wr_data`=0; `wr_mask`=0.
- All outputs are registered except `pix_ready`, which is a combinational function of state, lane, `wr_full` and `wr_count`.
- Latency:
  - From 4th pixel accepted to `wr_en`: 1 cycle.
  - From final `wr_en` to `cmd_en`: at least 1 cycle, plus the number of `cmd_full` cycles.
  - From the last `cmd_en` to `frame_done`: 1 cycle.
- Maximum throughput is one pixel per clock, with a stall of at least 1 cycle per burst for CMD.
- `wr_full` rising while lane 3 is pending stalls only lane 3; lanes 0-2 keep accepting pixels.

## Configuration

- `VRAM_WRITER_KEYMASK_EN` defined: `wr_mask[i]` = (pixel in lane i == `KEY`), captured alongside the data. Keyed pixels leave memory unchanged, which gives an overlay write.
- `VRAM_WRITER_KEYMASK_EN` undefined: `wr_mask` is constant 4'b0000 and `KEY` is unused.

## Test plan

- Frame, with `BURST_WORDS`=4, `FRAME_WORDS`=10, `BASE_ADDR`=0x100: stream pixels 0..39 continuously.
  - `wr_en` pushes 0x03020100 ... 0x27262524 (10 pushes).
  - `cmd_en` fires 3 times: (0x100, bl 3), (0x110, bl 3), (0x120, bl 1).
  - One `frame_done`, then `busy`=0.
- Write backpressure: hold `wr_full`=1 while lane 3 is pending.
  - `pix_ready` stays 0 and no `wr_en` occurs.
  - When `wr_full` is released, the push occurs 1 cycle after the 4th pixel is accepted.
- Command stall: hold `cmd_full`=1 for 5 cycles in CMD.
  - `cmd_en` is asserted exactly once, on the cycle after release.
  - `pix_ready`=0 throughout the stall.
- Calibration gating: `start` with `calib_done`=0.
  - Block stays in IDLE with `busy`=0.
  - A later `start` with `calib_done`=1 starts the frame at 0x100.
- Reset mid-frame: assert `reset`=0 after 6 pixels, release it, then start a new frame.
  - All outputs return to their reset values.
  - The first word of the new frame is packed from fresh pixels, and the first command address is 0x100.
- With `VRAM_WRITER_KEYMASK_EN` and `KEY`=0: pixels 00,11,00,33 produce `wr_data`=0x33001100 and `wr_mask`=4'b0101.
